decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Decode/issue stage feeding the 64-bit execute ALU. Holds the 32x64 integer register file.
//  Decodes one RV64 instruction per handshake into an ALU op code, operands and control.
//  Issues these from a registered output slot to EX, with valid/ready flow control and flush.
// PARAMETERS
//  XLEN        64   datapath/register width
//  NREGS       32   architectural registers (x0 hardwired zero)
//  ILLEGAL_OPR 4'hF ex_alu_opr value driven for undecodable instructions
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  if_valid     in   1     fetch presents if_instr/if_pc
//  if_ready     out  1     stage accepts this cycle
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  instruction address
//  wb_en        in   1     register-file write enable
//  wb_rd        in   5     write address
//  wb_data      in   XLEN  write data
//  flush        in   1     kill slot contents and incoming instruction
//  ex_ready     in   1     EX consumes slot this cycle
//  ex_valid     out  1     slot holds an issued instruction
//  ex_alu_opr   out  4     ALU op code (encoding below)
//  ex_op1       out  XLEN  rs1 data
//  ex_op2       out  XLEN  rs2 data (R-type, branch) or sign-extended imm (I/load/store)
//  ex_store_data out XLEN  rs2 data for sd
//  ex_imm       out  XLEN  sign-extended immediate (branch offset for B-type)
//  ex_pc        out  XLEN  pc of issued instruction
//  ex_rd        out  5     destination register
//  ex_reg_write out  1     writes rd
//  ex_mem_read  out  1     ld
//  ex_mem_write out  1     sd
//  ex_branch    out  1     conditional branch
//  ex_illegal   out  1     undecodable instruction
// BEHAVIOUR
//  ALU codes: 0 add, 1 sub, 2 sll, 3 xor, 4 srl, 5 or, 6 and, 7 beq, 8 bne, 9 blt, A bge.
//  Decoded set: add/sub/sll/xor/srl/or/and; addi/xori/ori/andi/slli/srli (shamt 6b); ld, sd -> opr 0;
//   beq/bne/blt/bge -> opr 7..A. Any other opcode/funct: ex_illegal=1, opr=ILLEGAL_OPR, controls 0.
//  Immediates: I/S/B formats sign-extended to XLEN; B imm bit0=0.
//  if_ready = !ex_valid | ex_ready. Transfer when if_valid & if_ready.
//  Latency: 1 cycle, transfer at edge N -> ex_* valid after edge N.
//  Slot load on transfer; slot clears (ex_valid=0) when ex_ready & !transfer.
//  Stall (ex_valid & !ex_ready): every ex_* output held bit-stable.
//  Register file: write on wb_en & wb_rd!=0 at clock edge; x0 reads 0 always; writes to x0 dropped.
//  Operands captured at transfer edge. A later wb to rs does not update a stalled slot.
//  flush: next edge ex_valid=0, incoming instr dropped even if if_valid; if_ready=1 during flush.
//   wb writes proceed during flush.
//  Reset: ex_valid=0, all ex_* outputs 0, all registers 0; regfile clear completes in one cycle.
//   Reset mid-stall discards the held instruction. wb ignored while rst=1.
//  Priority per edge: rst > flush > transfer > drain.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: same-cycle wb_en & wb_rd==rs (rs!=0) returns wb_data as operand.
//  RF_WB_BYPASS_EN undefined: read returns pre-write value. Write visible from the next cycle.
// TESTING
//  1. Reset 2 cycles, wb x1=5, x2=3, issue add x3,x1,x2 (0x002081B3) -> opr=0, op1=5, op2=3, rd=3,
//     reg_write=1.
//  2. sub, then bge x1,x2,+8 -> opr=1. Then opr=A, op2=3, imm=8, branch=1, reg_write=0.
//  3. ld x4,-16(x1) -> opr=0, op2=0xFFFF_FFFF_FFFF_FFF0, mem_read=1. sd -> mem_write=1,
//     store_data=rs2.
//  4. ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, outputs stable; ex_ready=1 -> next
//     instr issued the following cycle, none lost or duplicated.
//  5. Issue add x5,x1,x2 while wb x1=9 same cycle -> op1=9 with RF_WB_BYPASS_EN, 5 without.
//     wb x0=7 -> reads 0.
//  6. flush with if_valid=1 and full slot -> ex_valid=0 next cycle.
//     Illegal word 0xFFFFFFFF -> ex_illegal=1, opr=F.

Source files
------------

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV64 decode, 32x64 integer register file and one registered issue slot to EX.
// Latency: 1 cycle from the if_valid/if_ready transfer edge to ex_valid; operands are captured at that edge.
// Backpressure: if_ready = !ex_valid | ex_ready (forced 1 during flush); stalled slot outputs held bit-stable.
// Optional feature macro RF_WB_BYPASS_EN: a same-cycle writeback is forwarded to rs1/rs2 reads.
module decode_issue_stage #(
  parameter int          XLEN        = 64,
  parameter int          NREGS       = 32,
  parameter logic [3:0]  ILLEGAL_OPR = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_opr,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal
);

  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            transfer;

  logic [3:0]      d_opr;
  logic [XLEN-1:0] d_op1, d_op2, d_sd, d_imm;
  logic [4:0]      d_rd;
  logic            d_rw, d_mr, d_mw, d_br, d_ill, legal;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign funct7 = if_instr[31:25];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign imm_i  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s  = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b  = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};

  // Flush drops the incoming instruction but still reports ready so fetch is never blocked by it.
  assign if_ready = flush | ~ex_valid | ex_ready;
  assign transfer = if_valid & if_ready & ~flush;

  // Register file: x0 is never written; reset clears every entry in one cycle and masks writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Operand read; x0 always reads zero, optional same-cycle writeback forwarding.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
`ifdef RF_WB_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1) rs1_val = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2) rs2_val = wb_data;
`endif
  end

  // Instruction decode into ALU op, operands and control; anything unrecognised becomes illegal.
  always_comb begin
    legal = 1'b1;
    d_opr = 4'd0;
    d_op1 = '0;
    d_op2 = '0;
    d_sd  = '0;
    d_imm = '0;
    d_rd  = 5'd0;
    d_rw  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_br  = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      7'b0110011: begin
        d_op1 = rs1_val;
        d_op2 = rs2_val;
        d_rd  = rd;
        d_rw  = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: d_opr = 4'd0;
          {7'h20, 3'd0}: d_opr = 4'd1;
          {7'h00, 3'd1}: d_opr = 4'd2;
          {7'h00, 3'd4}: d_opr = 4'd3;
          {7'h00, 3'd5}: d_opr = 4'd4;
          {7'h00, 3'd6}: d_opr = 4'd5;
          {7'h00, 3'd7}: d_opr = 4'd6;
          default:       legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        // Shift immediates carry a 6-bit shamt; upper imm bits must be zero (srai is not supported).
        d_op1 = rs1_val;
        d_op2 = imm_i;
        d_imm = imm_i;
        d_rd  = rd;
        d_rw  = 1'b1;
        case (funct3)
          3'd0: d_opr = 4'd0;
          3'd4: d_opr = 4'd3;
          3'd6: d_opr = 4'd5;
          3'd7: d_opr = 4'd6;
          3'd1: begin d_opr = 4'd2; legal = (if_instr[31:26] == 6'd0); end
          3'd5: begin d_opr = 4'd4; legal = (if_instr[31:26] == 6'd0); end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d_op1 = rs1_val;
        d_op2 = imm_i;
        d_imm = imm_i;
        d_rd  = rd;
        d_rw  = 1'b1;
        d_mr  = 1'b1;
        legal = (funct3 == 3'd3);
      end
      7'b0100011: begin
        d_op1 = rs1_val;
        d_op2 = imm_s;
        d_imm = imm_s;
        d_sd  = rs2_val;
        d_mw  = 1'b1;
        legal = (funct3 == 3'd3);
      end
      7'b1100011: begin
        d_op1 = rs1_val;
        d_op2 = rs2_val;
        d_imm = imm_b;
        d_br  = 1'b1;
        case (funct3)
          3'd0:    d_opr = 4'd7;
          3'd1:    d_opr = 4'd8;
          3'd4:    d_opr = 4'd9;
          3'd5:    d_opr = 4'hA;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d_opr = ILLEGAL_OPR;
      d_op1 = '0;
      d_op2 = '0;
      d_sd  = '0;
      d_imm = '0;
      d_rd  = 5'd0;
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
      d_ill = 1'b1;
    end
  end

  // Issue slot: reset > flush > load on transfer > drain when EX consumes; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_alu_opr    <= 4'd0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_store_data <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid      <= 1'b1;
      ex_alu_opr    <= d_opr;
      ex_op1        <= d_op1;
      ex_op2        <= d_op2;
      ex_store_data <= d_sd;
      ex_imm        <= d_imm;
      ex_pc         <= if_pc;
      ex_rd         <= d_rd;
      ex_reg_write  <= d_rw;
      ex_mem_read   <= d_mr;
      ex_mem_write  <= d_mw;
      ex_branch     <= d_br;
      ex_illegal    <= d_ill;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed scenarios plus randomized traffic against a mnemonic-level model.
// Expected issue contents are built from the instruction's meaning (mnemonic, regs, immediate).
// Honours RF_WB_BYPASS_EN the same way the design does.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, wb_en, flush, ex_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [3:0]  ex_alu_opr;
  logic [63:0] ex_op1, ex_op2, ex_store_data, ex_imm, ex_pc;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_opr(ex_alu_opr), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [3:0]  opr;
    logic [63:0] op1, op2, sd, imm, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
  } exp_t;

  exp_t dut_s;
  assign dut_s = {ex_alu_opr, ex_op1, ex_op2, ex_store_data, ex_imm, ex_pc, ex_rd,
                  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal};

  // Mnemonics 0..19: add sub sll xor srl or and | addi xori ori andi slli srli | ld | sd |
  // beq bne blt bge | illegal
  int opr_t[20] = '{0, 1, 2, 3, 4, 5, 6, 0, 3, 5, 6, 2, 4, 0, 0, 7, 8, 9, 10, 15};
  int f3_t[20]  = '{0, 0, 1, 4, 5, 6, 7, 0, 4, 6, 7, 1, 5, 3, 3, 0, 1, 4, 5, 0};

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 7, K_XORI = 8, K_SLLI = 11, K_SRLI = 12;
  localparam int K_LD = 13, K_SD = 14, K_BGE = 18, K_ILL = 19;

`ifdef RF_WB_BYPASS_EN
  localparam logic [63:0] BYP_X1 = 64'd9;
`else
  localparam logic [63:0] BYP_X1 = 64'd5;
`endif

  logic [63:0] m_rf [32];
  logic        m_valid = 1'b0;
  exp_t        m_exp = '0;
  int          cur_k, cur_rd, cur_rs1, cur_rs2;
  logic [63:0] cur_imm;
  int          n_cmp = 0, n_bad = 0;

  function automatic int cls(int k);
    if (k <= 6) return 0;
    if (k <= 12) return 1;
    if (k == K_LD) return 2;
    if (k == K_SD) return 3;
    if (k <= 18) return 4;
    return 5;
  endfunction

  function automatic logic [63:0] reg_val(int r);
    if (r == 0) return 64'd0;
`ifdef RF_WB_BYPASS_EN
    if (wb_en && int'(wb_rd) == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  // What EX should see for the currently presented instruction, from its meaning.
  function automatic exp_t expect_now();
    exp_t e = '0;
    e.pc  = if_pc;
    e.opr = 4'(opr_t[cur_k]);
    case (cls(cur_k))
      0: begin e.op1 = reg_val(cur_rs1); e.op2 = reg_val(cur_rs2); e.rd = 5'(cur_rd); e.rw = 1; end
      1, 2: begin
        e.op1 = reg_val(cur_rs1); e.op2 = cur_imm; e.imm = cur_imm; e.rd = 5'(cur_rd); e.rw = 1;
        e.mr = (cur_k == K_LD);
      end
      3: begin e.op1 = reg_val(cur_rs1); e.op2 = cur_imm; e.imm = cur_imm; e.sd = reg_val(cur_rs2); e.mw = 1; end
      4: begin e.op1 = reg_val(cur_rs1); e.op2 = reg_val(cur_rs2); e.imm = cur_imm; e.br = 1; end
      default: begin e.opr = 4'hF; e.ill = 1; end
    endcase
    return e;
  endfunction

  task automatic set_instr(int k, int rdn, int r1, int r2, logic [63:0] imm, logic [63:0] pc);
    logic [4:0] d, a, b;
    logic [2:0] f3;
    d = 5'(rdn); a = 5'(r1); b = 5'(r2); f3 = 3'(f3_t[k]);
    cur_k = k; cur_rd = rdn; cur_rs1 = r1; cur_rs2 = r2; cur_imm = imm; if_pc = pc;
    case (cls(k))
      0: if_instr = {(k == K_SUB) ? 7'h20 : 7'h00, b, a, f3, d, 7'b0110011};
      1: if_instr = {imm[11:0], a, f3, d, 7'b0010011};
      2: if_instr = {imm[11:0], a, f3, d, 7'b0000011};
      3: if_instr = {imm[11:5], b, a, f3, imm[4:0], 7'b0100011};
      4: if_instr = {imm[12], imm[10:5], b, a, f3, imm[4:1], imm[11], 7'b1100011};
      default: if_instr = 32'hFFFF_FFFF;
    endcase
  endtask

  task automatic idle();
    rst = 0; if_valid = 0; wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic wb(int r, logic [63:0] v);
    wb_en = 1; wb_rd = 5'(r); wb_data = v;
  endtask

  // One clock: the model takes the same edge as the DUT, then we return at the falling edge.
  task automatic step();
    logic rdy, xfer;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_exp = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    end else begin
      rdy  = !m_valid || ex_ready || flush;
      xfer = if_valid && rdy && !flush;
      e    = expect_now();
      if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
      if (flush) m_valid = 0;
      else if (xfer) begin m_valid = 1; m_exp = e; end
      else if (ex_ready) m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step();
    rst = 0; wb(7, 64'hDEAD_BEEF); step();
    rst = 1; wb(9, 64'h55); if_valid = 1; set_instr(K_ADD, 3, 7, 9, 0, 64'h10);
    step(); step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_cmp++; if (dut_s !== exp_t'(0)) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", dut_s); end
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", if_ready); end
    idle(); if_valid = 1; set_instr(K_ADD, 3, 7, 9, 0, 64'h10); step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_op1 !== 64'd0 || ex_op2 !== 64'd0)
      begin n_bad++; $display("FAIL reset_regs_clear: got v=%b op1=%h op2=%h want 1/0/0", ex_valid, ex_op1, ex_op2); end
  endtask

  task automatic test_alu();
    idle(); wb(1, 64'd5); step();
    wb(2, 64'd3); step();
    wb_en = 0; if_valid = 1; set_instr(K_ADD, 3, 1, 2, 0, 64'h100); step();
    n_cmp++; if (ex_valid !== 1 || ex_alu_opr !== 4'd0 || ex_op1 !== 64'd5 || ex_op2 !== 64'd3 ||
                 ex_rd !== 5'd3 || ex_reg_write !== 1 || ex_pc !== 64'h100)
      begin n_bad++; $display("FAIL add: got %h want opr0 op1=5 op2=3 rd3 rw1", dut_s); end
  endtask

  task automatic test_branch();
    idle(); if_valid = 1; set_instr(K_SUB, 6, 1, 2, 0, 64'h104); step();
    n_cmp++; if (ex_alu_opr !== 4'd1 || ex_op1 !== 64'd5 || ex_op2 !== 64'd3)
      begin n_bad++; $display("FAIL sub: got opr=%h op1=%h op2=%h want 1/5/3", ex_alu_opr, ex_op1, ex_op2); end
    set_instr(K_BGE, 0, 1, 2, 64'd8, 64'h108); step();
    n_cmp++; if (ex_alu_opr !== 4'hA || ex_op2 !== 64'd3 || ex_imm !== 64'd8 || ex_branch !== 1 || ex_reg_write !== 0)
      begin n_bad++; $display("FAIL bge: got %h want opr A op2=3 imm=8 br1 rw0", dut_s); end
  endtask

  task automatic test_mem();
    idle(); if_valid = 1; set_instr(K_LD, 4, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10C); step();
    n_cmp++; if (ex_alu_opr !== 4'd0 || ex_op1 !== 64'd5 || ex_op2 !== 64'hFFFF_FFFF_FFFF_FFF0 || ex_mem_read !== 1 || ex_rd !== 5'd4)
      begin n_bad++; $display("FAIL ld: got %h want op2=-16 mr1", dut_s); end
    set_instr(K_SD, 0, 1, 2, 64'd8, 64'h110); step();
    n_cmp++; if (ex_mem_write !== 1 || ex_store_data !== 64'd3 || ex_op2 !== 64'd8 || ex_reg_write !== 0)
      begin n_bad++; $display("FAIL sd: got %h want mw1 sd=3 op2=8", dut_s); end
  endtask

  task automatic test_stall();
    idle(); if_valid = 1; ex_ready = 0; set_instr(K_ADDI, 10, 1, 0, 64'd7, 64'h200);
    for (int c = 0; c < 3; c++) begin
      wb(1, 64'd77);
      #1;
      n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready c%0d: got %b want 0", c, if_ready); end
      step();
      n_cmp++; if (ex_valid !== 1 || dut_s !== m_exp || ex_pc !== 64'h110)
        begin n_bad++; $display("FAIL stall_hold c%0d: got %h want %h", c, dut_s, m_exp); end
    end
    wb_en = 0; ex_ready = 1; #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", if_ready); end
    step();
    n_cmp++; if (ex_valid !== 1 || ex_pc !== 64'h200 || ex_op1 !== 64'd77 || ex_op2 !== 64'd7)
      begin n_bad++; $display("FAIL stall_next: got pc=%h op1=%h want 200/77", ex_pc, ex_op1); end
    if_valid = 0; step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got %b want 0 (duplicate)", ex_valid); end
    wb(1, 64'd5); step();
  endtask

  task automatic test_bypass();
    idle(); wb(1, 64'd9); if_valid = 1; set_instr(K_ADD, 5, 1, 2, 0, 64'h300); step();
    n_cmp++; if (ex_op1 !== BYP_X1) begin n_bad++; $display("FAIL wb_same_cycle: got %h want %h", ex_op1, BYP_X1); end
    wb_en = 0; set_instr(K_ADD, 5, 1, 2, 0, 64'h304); step();
    n_cmp++; if (ex_op1 !== 64'd9) begin n_bad++; $display("FAIL wb_next_cycle: got %h want 9", ex_op1); end
    if_valid = 0; wb(0, 64'd7); step();
    wb_en = 0; if_valid = 1; set_instr(K_ADD, 6, 0, 1, 0, 64'h308); step();
    n_cmp++; if (ex_op1 !== 64'd0 || ex_op2 !== 64'd9) begin n_bad++; $display("FAIL x0_zero: got %h/%h want 0/9", ex_op1, ex_op2); end
  endtask

  task automatic test_flush_illegal();
    idle(); if_valid = 1; ex_ready = 0; set_instr(K_ADDI, 11, 2, 0, 64'd1, 64'h400); step();
    flush = 1; set_instr(K_XORI, 12, 2, 0, 64'd1, 64'h404); wb(8, 64'h123); #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", if_ready); end
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got %b want 0", ex_valid); end
    idle(); step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop: got %b want 0", ex_valid); end
    if_valid = 1; set_instr(K_ILL, 0, 0, 0, 0, 64'h408); step();
    n_cmp++; if (ex_illegal !== 1 || ex_alu_opr !== 4'hF || ex_reg_write !== 0 || ex_valid !== 1)
      begin n_bad++; $display("FAIL illegal: got %h want ill1 opr F", dut_s); end
    set_instr(K_ADD, 12, 8, 0, 0, 64'h40C); step();
    n_cmp++; if (ex_op1 !== 64'h123) begin n_bad++; $display("FAIL flush_wb: got %h want 123", ex_op1); end
  endtask

  task automatic test_random();
    int k;
    logic [11:0] t;
    logic [63:0] imm;
    idle();
    for (int c = 0; c < 600; c++) begin
      k = $urandom_range(0, 19);
      t = 12'($urandom);
      case (cls(k))
        1: imm = (k == K_SLLI || k == K_SRLI) ? 64'($urandom_range(0, 63)) : {{52{t[11]}}, t};
        2, 3: imm = {{52{t[11]}}, t};
        4: imm = {{51{t[11]}}, t, 1'b0};
        default: imm = 64'd0;
      endcase
      set_instr(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm,
                {32'd0, 32'($urandom)});
      rst      = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      wb_en    = ($urandom_range(0, 1) == 0);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = {$urandom, $urandom};
      #1;
      n_cmp++; if (!rst && if_ready !== (!m_valid || ex_ready || flush))
        begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, if_ready, !m_valid || ex_ready || flush); end
      step();
      n_cmp++; if (ex_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, ex_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (dut_s !== m_exp) begin n_bad++; $display("FAIL rand_slot c%0d: got %h want %h", c, dut_s, m_exp); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    idle(); rst = 1; if_instr = 32'd0; if_pc = 64'd0; cur_k = K_ADD;
    cur_rd = 0; cur_rs1 = 0; cur_rs2 = 0; cur_imm = 64'd0;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_stall();
    test_bypass();
    test_flush_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
